// File: rtl/ok_alu_pkg.sv
// Shared definitions for the okWire ALU: mode encodings and default sizes.
package ok_alu_pkg;

  localparam int MODE_W      = 2;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NCH     = 4;
  localparam int DEF_COUNT_W = 16;

  typedef enum logic [MODE_W-1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_ACC  = 2'd2,
    MODE_HOLD = 2'd3
  } mode_t;

endpackage

// File: rtl/ok_alu_chan.sv
// One ALU channel: stage-1 input capture, stage-2 add/sub/accumulate with
// sticky overflow, saturating accumulation counter and done pulse.
// Optional macro OK_WIRE_ALU_SATURATE_EN: ADD/ACC clamp to all-ones on
// carry and SUB clamps to zero on borrow instead of wrapping.
module ok_alu_chan
  import ok_alu_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               okClk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [MODE_W-1:0]  mode,
  input  logic               acc_trig,
  input  logic               clr_trig,
  output logic [WIDTH-1:0]   result,
  output logic               ovf,
  output logic [COUNT_W-1:0] acc_count,
  output logic               done
);

`ifdef OK_WIRE_ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [WIDTH-1:0]   ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};

  // Stage-1 registers
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  mode_t              mode_r;
  logic               acc_trig_r;
  logic               clr_trig_r;
  logic [WIDTH-1:0]   acc_r;

  // Stage-2 combinational results
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH:0]     acc_sum_s;
  logic [WIDTH-1:0]   add_val_s;
  logic [WIDTH-1:0]   sub_val_s;
  logic [WIDTH-1:0]   acc_val_s;
  logic [WIDTH-1:0]   acc_nxt_s;
  logic [WIDTH-1:0]   res_nxt_s;
  logic [COUNT_W-1:0] cnt_nxt_s;
  logic               fire_s;
  logic               ovf_set_s;
  logic               ovf_nxt_s;

  // Stage 1: capture operands, mode and trigger pulses.
  always_ff @(posedge okClk) begin
    if (reset) begin
      a_r        <= ZERO_W;
      b_r        <= ZERO_W;
      mode_r     <= MODE_ADD;
      acc_trig_r <= 1'b0;
      clr_trig_r <= 1'b0;
    end else begin
      a_r        <= a;
      b_r        <= b;
      mode_r     <= mode_t'(mode);
      acc_trig_r <= acc_trig;
      clr_trig_r <= clr_trig;
    end
  end

  // Stage 2 next-state: arithmetic, clear-over-accumulate priority, flags.
  always_comb begin
    sum_s     = {1'b0, a_r} + {1'b0, b_r};
    diff_s    = {1'b0, a_r} - {1'b0, b_r};
    acc_sum_s = {1'b0, acc_r} + {1'b0, a_r};
    fire_s    = acc_trig_r & ~clr_trig_r;
    add_val_s = (SAT && sum_s[WIDTH])     ? ALL_ONES : sum_s[WIDTH-1:0];
    sub_val_s = (SAT && diff_s[WIDTH])    ? ZERO_W   : diff_s[WIDTH-1:0];
    acc_val_s = (SAT && acc_sum_s[WIDTH]) ? ALL_ONES : acc_sum_s[WIDTH-1:0];

    if (clr_trig_r) begin
      acc_nxt_s = ZERO_W;
    end else if (fire_s) begin
      acc_nxt_s = acc_val_s;
    end else begin
      acc_nxt_s = acc_r;
    end

    if (clr_trig_r) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (fire_s && (acc_count != CNT_MAX)) begin
      cnt_nxt_s = acc_count + COUNT_W'(1);
    end else begin
      cnt_nxt_s = acc_count;
    end

    ovf_set_s = fire_s & acc_sum_s[WIDTH];
    res_nxt_s = result;
    case (mode_r)
      MODE_ADD: begin
        res_nxt_s = add_val_s;
        ovf_set_s = ovf_set_s | sum_s[WIDTH];
      end
      MODE_SUB: begin
        res_nxt_s = sub_val_s;
        ovf_set_s = ovf_set_s | diff_s[WIDTH];
      end
      MODE_ACC: begin
        res_nxt_s = acc_nxt_s;
      end
      MODE_HOLD: begin
        if (clr_trig_r) begin
          res_nxt_s = ZERO_W;
        end else begin
          res_nxt_s = result;
        end
      end
      default: begin
        res_nxt_s = result;
      end
    endcase

    if (clr_trig_r) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf | ovf_set_s;
    end
  end

  // Stage 2 registers: accumulator and all channel outputs.
  always_ff @(posedge okClk) begin
    if (reset) begin
      acc_r     <= ZERO_W;
      result    <= ZERO_W;
      ovf       <= 1'b0;
      acc_count <= CNT_ZERO;
      done      <= 1'b0;
    end else begin
      acc_r     <= acc_nxt_s;
      result    <= res_nxt_s;
      ovf       <= ovf_nxt_s;
      acc_count <= cnt_nxt_s;
      done      <= fire_s;
    end
  end

endmodule

// File: rtl/ok_wire_alu.sv
// Multi-channel okWire ALU top: slices the packed host buses and
// instantiates one independent ok_alu_chan per channel.
// Optional macro OK_WIRE_ALU_SATURATE_EN (handled inside ok_alu_chan).
module ok_wire_alu
  import ok_alu_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NCH     = DEF_NCH,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic                   okClk,
  input  logic                   reset,
  input  logic [NCH*WIDTH-1:0]   op_a,
  input  logic [NCH*WIDTH-1:0]   op_b,
  input  logic [NCH*MODE_W-1:0]  mode,
  input  logic [NCH-1:0]         acc_trig,
  input  logic [NCH-1:0]         clr_trig,
  output logic [NCH*WIDTH-1:0]   result,
  output logic [NCH-1:0]         ovf,
  output logic [NCH*COUNT_W-1:0] acc_count,
  output logic [NCH-1:0]         done
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    ok_alu_chan #(
      .WIDTH   (WIDTH),
      .COUNT_W (COUNT_W)
    ) u_chan (
      .okClk     (okClk),
      .reset     (reset),
      .a         (op_a[c*WIDTH +: WIDTH]),
      .b         (op_b[c*WIDTH +: WIDTH]),
      .mode      (mode[c*MODE_W +: MODE_W]),
      .acc_trig  (acc_trig[c]),
      .clr_trig  (clr_trig[c]),
      .result    (result[c*WIDTH +: WIDTH]),
      .ovf       (ovf[c]),
      .acc_count (acc_count[c*COUNT_W +: COUNT_W]),
      .done      (done[c])
    );
  end

endmodule

// File: tb/tb_ok_wire_alu.sv
// Scoreboard bench for ok_wire_alu: stimulus pushes hand-computed
// expectations tagged with the cycle they are due; a negedge monitor pops
// and compares them. A second 1-channel instance with COUNT_W=2 covers
// counter saturation.
module tb_ok_wire_alu;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int CW = 16;

`ifdef OK_WIRE_ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic           okClk = 1'b0;
  logic           reset;
  logic [N*W-1:0] op_a, op_b;
  logic [N*2-1:0] mode;
  logic [N-1:0]   acc_trig, clr_trig;
  logic [N*W-1:0] result;
  logic [N-1:0]   ovf;
  logic [N*CW-1:0] acc_count;
  logic [N-1:0]   done;

  logic [W-1:0] s_op_a, s_op_b, s_result;
  logic [1:0]   s_mode, s_count;
  logic         s_acc, s_clr, s_ovf, s_done;

  ok_wire_alu #(.WIDTH(W), .NCH(N), .COUNT_W(CW)) dut (
    .okClk(okClk), .reset(reset), .op_a(op_a), .op_b(op_b), .mode(mode),
    .acc_trig(acc_trig), .clr_trig(clr_trig), .result(result), .ovf(ovf),
    .acc_count(acc_count), .done(done)
  );

  ok_wire_alu #(.WIDTH(W), .NCH(1), .COUNT_W(2)) dut_s (
    .okClk(okClk), .reset(reset), .op_a(s_op_a), .op_b(s_op_b), .mode(s_mode),
    .acc_trig(s_acc), .clr_trig(s_clr), .result(s_result), .ovf(s_ovf),
    .acc_count(s_count), .done(s_done)
  );

  always #5 okClk = ~okClk;

  int cyc = 0;
  always @(posedge okClk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    int           ch;
    int           fld;
    logic [W-1:0] val;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // fld: 0 result, 1 ovf, 2 acc_count, 3 done, 4 small count, 5 small result,
  //      6 small done, 7 small ovf
  function automatic logic [W-1:0] observe(int ch, int fld);
    case (fld)
      0: return result[ch*W +: W];
      1: return W'(ovf[ch]);
      2: return W'(acc_count[ch*CW +: CW]);
      3: return W'(done[ch]);
      4: return W'(s_count);
      5: return s_result;
      6: return W'(s_done);
      7: return W'(s_ovf);
      default: return {W{1'b1}};
    endcase
  endfunction

  task automatic expect_at(int dly, int ch, int fld, logic [W-1:0] val, string name);
    exp_t e;
    e.cyc = cyc + dly;
    e.ch = ch;
    e.fld = fld;
    e.val = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge okClk);
    #1;
  endtask

  task automatic set_ch(int ch, logic [1:0] m, logic [W-1:0] a, logic [W-1:0] b);
    mode[ch*2 +: 2] = m;
    op_a[ch*W +: W] = a;
    op_b[ch*W +: W] = b;
  endtask

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge okClk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [W-1:0] act;
        act = observe(sb[i].ch, sb[i].fld);
        checks++;
        if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s ch%0d cyc%0d: got %h expected %h",
                   sb[i].name, sb[i].ch, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    // Reset with nonzero inputs and pending triggers.
    reset = 1'b1;
    op_a = {N{32'hA5A5_0003}};
    op_b = {N{32'h0000_0011}};
    mode = 8'hAA;
    acc_trig = 4'hF;
    clr_trig = 4'h0;
    s_op_a = 32'd7; s_op_b = 32'd0; s_mode = 2'd2; s_acc = 1'b1; s_clr = 1'b0;
    step(3);
    for (int c = 0; c < N; c++) begin
      expect_at(0, c, 0, 32'd0, "rst_result");
      expect_at(0, c, 1, 32'd0, "rst_ovf");
      expect_at(0, c, 2, 32'd0, "rst_count");
      expect_at(0, c, 3, 32'd0, "rst_done");
    end
    expect_at(0, 0, 4, 32'd0, "rst_s_count");

    // Release; ch0 ADD 5+7 appears exactly two cycles later.
    reset = 1'b0;
    op_a = '0; op_b = '0; mode = '0; acc_trig = '0;
    s_acc = 1'b0; s_op_a = 32'd1; s_mode = 2'd0;
    set_ch(0, 2'd0, 32'd5, 32'd7);
    set_ch(1, 2'd0, 32'd4, 32'd5);
    expect_at(1, 0, 0, 32'd0, "add_lat1");
    expect_at(2, 0, 0, 32'd12, "add_5_7");
    step(2);

    // ADD carry-out, sticky ovf, then clear.
    set_ch(0, 2'd0, 32'hFFFF_FFFF, 32'd2);
    expect_at(2, 0, 0, SAT ? 32'hFFFF_FFFF : 32'd1, "add_ovf_result");
    expect_at(2, 0, 1, 32'd1, "add_ovf_flag");
    step(1);
    set_ch(0, 2'd0, 32'd0, 32'd0);
    expect_at(2, 0, 0, 32'd0, "add_zero");
    expect_at(2, 0, 1, 32'd1, "ovf_sticky");
    expect_at(3, 0, 1, 32'd1, "ovf_sticky2");
    step(2);
    set_ch(0, 2'd0, 32'd4, 32'd4);
    clr_trig[0] = 1'b1;
    expect_at(2, 0, 0, 32'd8, "clr_add_result");
    expect_at(2, 0, 1, 32'd0, "clr_ovf");
    step(1);
    clr_trig[0] = 1'b0;
    step(2);

    // SUB borrow.
    set_ch(0, 2'd1, 32'd3, 32'd5);
    expect_at(2, 0, 0, SAT ? 32'd0 : 32'hFFFF_FFFE, "sub_borrow_result");
    expect_at(2, 0, 1, 32'd1, "sub_borrow_flag");
    step(1);
    set_ch(0, 2'd0, 32'd0, 32'd0);
    step(2);

    // ACC burst on ch2: four back-to-back triggers with a=10.
    set_ch(2, 2'd2, 32'd10, 32'd0);
    for (int i = 0; i < 4; i++) begin
      acc_trig[2] = 1'b1;
      expect_at(2, 2, 0, 32'(10 * (i + 1)), "acc_burst_result");
      expect_at(2, 2, 3, 32'd1, "acc_burst_done");
      expect_at(2, 2, 2, 32'(i + 1), "acc_burst_count");
      step(1);
    end
    acc_trig[2] = 1'b0;
    expect_at(2, 2, 3, 32'd0, "acc_done_low");
    expect_at(2, 2, 0, 32'd40, "acc_hold40");
    expect_at(2, 2, 2, 32'd4, "acc_count4");
    step(1);

    // Clear and accumulate together: clear wins.
    clr_trig[2] = 1'b1;
    acc_trig[2] = 1'b1;
    expect_at(2, 2, 0, 32'd0, "collide_result");
    expect_at(2, 2, 2, 32'd0, "collide_count");
    expect_at(2, 2, 3, 32'd0, "collide_done");
    step(1);
    clr_trig[2] = 1'b0;
    acc_trig[2] = 1'b0;
    set_ch(2, 2'd2, 32'd1, 32'd0);
    step(1);
    acc_trig[2] = 1'b1;
    expect_at(2, 2, 0, 32'd1, "post_clr_result");
    expect_at(2, 2, 3, 32'd1, "post_clr_done");
    expect_at(2, 2, 2, 32'd1, "post_clr_count");
    step(1);
    acc_trig[2] = 1'b0;
    step(2);

    // ACC carry-out on ch3.
    set_ch(3, 2'd2, 32'hFFFF_FFFF, 32'd0);
    acc_trig[3] = 1'b1;
    expect_at(2, 3, 0, 32'hFFFF_FFFF, "acc_first");
    expect_at(2, 3, 1, 32'd0, "acc_no_ovf");
    step(1);
    expect_at(2, 3, 0, SAT ? 32'hFFFF_FFFF : 32'hFFFF_FFFE, "acc_ovf_result");
    expect_at(2, 3, 1, 32'd1, "acc_ovf_flag");
    step(1);
    acc_trig[3] = 1'b0;
    step(2);

    // ch1 HOLD at 9 while ch2 accumulates; ch1 trigger counts but result holds.
    set_ch(1, 2'd3, 32'd100, 32'd100);
    acc_trig[1] = 1'b1;
    acc_trig[2] = 1'b1;
    expect_at(2, 1, 0, 32'd9, "hold_result");
    expect_at(2, 1, 2, 32'd1, "hold_count");
    expect_at(2, 1, 3, 32'd1, "hold_done");
    expect_at(2, 2, 0, 32'd2, "indep_ch2_a");
    expect_at(2, 2, 3, 32'd1, "indep_ch2_done");
    step(1);
    acc_trig[1] = 1'b0;
    expect_at(2, 1, 0, 32'd9, "hold_result2");
    expect_at(2, 1, 3, 32'd0, "hold_done_low");
    expect_at(2, 1, 2, 32'd1, "hold_count2");
    expect_at(2, 2, 0, 32'd3, "indep_ch2_b");
    step(1);
    acc_trig[2] = 1'b0;
    clr_trig[1] = 1'b1;
    expect_at(2, 1, 0, 32'd0, "hold_clr_result");
    expect_at(2, 1, 2, 32'd0, "hold_clr_count");
    expect_at(2, 2, 0, 32'd3, "indep_ch2_c");
    step(1);
    clr_trig[1] = 1'b0;
    step(2);

    // Counter saturation on the COUNT_W=2 instance.
    s_mode = 2'd2;
    s_op_a = 32'd1;
    for (int i = 0; i < 5; i++) begin
      s_acc = 1'b1;
      expect_at(2, 0, 4, (i < 3) ? 32'(i + 1) : 32'd3, "sat_count");
      expect_at(2, 0, 5, 32'(i + 1), "sat_result");
      expect_at(2, 0, 6, 32'd1, "sat_done");
      step(1);
    end
    s_acc = 1'b0;
    expect_at(2, 0, 4, 32'd3, "sat_count_stick");
    expect_at(2, 0, 7, 32'd0, "sat_ovf");
    step(1);

    // Drain outstanding expectations with a bounded wait.
    for (int k = 0; k < 10 && sb.size() > 0; k++) step(1);
    if (sb.size() > 0) begin
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      errors += sb.size();
      checks += sb.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ok_wire_alu.md
Name: ok_wire_alu

Overview:
- Parametrised multi-channel arithmetic block between okWireIn/okTriggerIn endpoints and okWireOut/okTriggerOut endpoints, clocked on okClk.
- Each channel has a host-selected mode: add, subtract, accumulate or hold.
- Results are pipelined and registered. Each channel adds sticky overflow, an accumulation counter and a completion pulse for the host to poll or trigger on.

Parameters:
- WIDTH, 32, operand/result width per channel (matches one wire endpoint).
- NCH, 4, number of independent channels.
- COUNT_W, 16, accumulation-counter width per channel.

Ports:
- okClk  in  1  host interface clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- op_a  in  NCH*WIDTH  operand A; channel c at [c*WIDTH +: WIDTH].
- op_b  in  NCH*WIDTH  operand B, same packing.
- mode  in  NCH*2  per-channel mode: 0 ADD, 1 SUB, 2 ACC, 3 HOLD.
- acc_trig  in  NCH  one-cycle accumulate request per channel (TriggerIn pulse).
- clr_trig  in  NCH  one-cycle clear request per channel.
- result  out  NCH*WIDTH  registered result per channel.
- ovf  out  NCH  sticky overflow per channel.
- acc_count  out  NCH*COUNT_W  accumulations since last clear, per channel.
- done  out  NCH  one-cycle pulse when an accumulation lands in result.

Behaviour:
- Interface: one clock, okClk. reset is synchronous and active-high. While reset is high, at each edge: result, ovf, acc_count, done and all internal state (pipeline registers, accumulators) go to 0. In-flight triggers are discarded.
- Pipeline stage 1 registers op_a, op_b, mode, acc_trig and clr_trig.
- Pipeline stage 2 computes from the stage-1 registers and updates result, ovf, acc_count and done. Latency from any input change to result is 2 cycles.
- ADD: result <= a+b, mod 2^WIDTH, recomputed every cycle. ovf is set on carry-out.
- SUB: result <= a-b, mod 2^WIDTH. ovf is set on borrow (a<b, unsigned).
- ACC: result mirrors the accumulator acc.
  - On a staged acc_trig: acc <= acc + a; result shows the new value in the same edge.
  - ovf is set on carry-out.
  - acc_count increments, saturating at 2^COUNT_W-1 with no wrap.
  - done pulses high for exactly that cycle.
- HOLD: result keeps its last value. acc_trig is still honoured: acc, acc_count, ovf and done update, but result does not.
- acc_trig in ADD or SUB mode: acc, acc_count, ovf and done update; result follows the ADD/SUB value.
- clr_trig: acc, acc_count and ovf go to 0. result goes to 0 only in ACC or HOLD mode; in ADD or SUB mode it keeps showing the computation.
- clr_trig and acc_trig in the same cycle on one channel: clear wins, the accumulation is dropped and done stays low.
- Back-to-back acc_trig every cycle: every trigger is accepted and gives one done pulse, 2 cycles later. No throughput loss.
- ovf stays sticky until clr_trig or reset. Setting and clearing in the same cycle: clear wins.
- Mode change: takes effect at stage-1 capture. A trigger already in stage 1 is executed against the newly staged mode.
- Channels are fully independent. No cross-channel interaction.

Optional Feature:
- Macro OK_WIRE_ALU_SATURATE_EN.
- Defined: ADD and ACC clamp to 2^WIDTH-1 on overflow, and SUB clamps to 0 on borrow. ovf is still set.
- Undefined: modular wrap as described above.
- Counter saturation is unaffected either way.

Decomposition:
- Shared package ok_alu_pkg holds:
  - mode encodings MODE_ADD, MODE_SUB, MODE_ACC, MODE_HOLD;
  - mode width constant MODE_W=2;
  - the default WIDTH/COUNT_W values.
- Natural sub-module ok_alu_chan (one channel: stages, acc, counter, flags). The top instantiates NCH copies with a generate loop and handles only bus slicing.

Test Plan:
- Reset: drive reset high 3 cycles with nonzero inputs -> every output 0. Release -> ch0 ADD with a=5, b=7 gives result 12 exactly 2 cycles after the operands are applied.
- ADD overflow, WIDTH=32: a=FFFFFFFF, b=2 -> result 1 and ovf=1; ovf stays 1 after the operands return to 0. clr_trig -> ovf 0. With SATURATE_EN: result FFFFFFFF.
- SUB borrow: a=3, b=5 -> result FFFFFFFE, ovf=1. With SATURATE_EN: result 0, ovf=1.
- ACC burst: a=10, four consecutive acc_trig pulses -> results 10, 20, 30, 40 on successive cycles starting 2 cycles after the first pulse. 4 done pulses, acc_count=4.
- Clear collision: clr_trig and acc_trig in the same cycle with acc=40 -> acc 0, acc_count 0, no done. A following acc_trig with a=1 -> result 1.
- Independence plus HOLD: ch1 HOLD at result 9, ch2 in ACC receiving triggers -> ch1 result stays 9. acc_trig on ch1 raises its acc_count while result stays 9. COUNT_W=2 -> acc_count sticks at 3 after 5 triggers.
